// File: rtl/axis_to_axi_ax_decoder.sv
// ============================================================================
// axis_to_axi_ax_decoder
//
// Receive end of the AXI-to-stream path. Each AXI4-Stream packet is expected
// to be a single beat carrying one AR or AW address transaction. The channel
// type comes from the low tdest bits; the Ax fields are unpacked from tdata.
// Every decoded transaction waits in a one-entry per-channel slot until its
// AXI master handshake completes. Multi-beat and unsupported-type packets are
// discarded and each drop raises a one-cycle decode_err pulse.
//
// tdata packing, LSB first:
//   addr[ADDR_WIDTH], len[BURST_LEN], size[3], burst[2], lock[LOCK_WIDTH],
//   cache[4], prot[3], region[4], qos[4]; remaining upper bits ignored.
// Channel types in tdest[STREAM_TYPE_WIDTH-1:0]: AR=0, AW=1, R=2, W=3, B=4.
//
// Ports
//   clk, reset          clock (rising edge) / asynchronous active-high reset
//   stream_t*           AXI4-Stream slave; tstrb/tkeep are ignored
//   AXIM_ar*/AXIM_aw*   registered AXI master address channels
//   decode_err          one-cycle pulse per dropped packet
//
// Optional build macro AXIS_TO_AXI_AX_STATS_EN adds saturating 32-bit
// counters: ar_count, aw_count (AXI handshakes) and drop_count (drops).
// ============================================================================
module axis_to_axi_ax_decoder #(
    parameter int DATA_WIDTH        = 128,
    parameter int ADDR_WIDTH        = 64,
    parameter int ID_WIDTH          = 32,
    parameter int BURST_LEN         = 8,
    parameter int LOCK_WIDTH        = 2,
    parameter int USER_WIDTH        = 64,
    parameter int DEST_WIDTH        = 32,
    parameter int STREAM_TYPE_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [ID_WIDTH-1:0]     stream_tid,
    input  logic [DEST_WIDTH-1:0]   stream_tdest,
    input  logic [DATA_WIDTH-1:0]   stream_tdata,
    input  logic [DATA_WIDTH/8-1:0] stream_tstrb,
    input  logic [DATA_WIDTH/8-1:0] stream_tkeep,
    input  logic                    stream_tlast,
    input  logic [USER_WIDTH-1:0]   stream_tuser,
    input  logic                    stream_tvalid,
    output logic                    stream_tready,

    output logic [ID_WIDTH-1:0]     AXIM_arid,
    output logic [ADDR_WIDTH-1:0]   AXIM_araddr,
    output logic [BURST_LEN-1:0]    AXIM_arlen,
    output logic [2:0]              AXIM_arsize,
    output logic [1:0]              AXIM_arburst,
    output logic [LOCK_WIDTH-1:0]   AXIM_arlock,
    output logic [3:0]              AXIM_arcache,
    output logic [2:0]              AXIM_arprot,
    output logic [3:0]              AXIM_arregion,
    output logic [3:0]              AXIM_arqos,
    output logic [USER_WIDTH-1:0]   AXIM_aruser,
    output logic                    AXIM_arvalid,
    input  logic                    AXIM_arready,

    output logic [ID_WIDTH-1:0]     AXIM_awid,
    output logic [ADDR_WIDTH-1:0]   AXIM_awaddr,
    output logic [BURST_LEN-1:0]    AXIM_awlen,
    output logic [2:0]              AXIM_awsize,
    output logic [1:0]              AXIM_awburst,
    output logic [LOCK_WIDTH-1:0]   AXIM_awlock,
    output logic [3:0]              AXIM_awcache,
    output logic [2:0]              AXIM_awprot,
    output logic [3:0]              AXIM_awregion,
    output logic [3:0]              AXIM_awqos,
    output logic [USER_WIDTH-1:0]   AXIM_awuser,
    output logic                    AXIM_awvalid,
    input  logic                    AXIM_awready,

    output logic                    decode_err
`ifdef AXIS_TO_AXI_AX_STATS_EN
    ,
    output logic [31:0]             ar_count,
    output logic [31:0]             aw_count,
    output logic [31:0]             drop_count
`endif
);

    // ------------------------------------------------------------------------
    // Field offsets inside tdata
    // ------------------------------------------------------------------------
    localparam int OFF_LEN    = ADDR_WIDTH;
    localparam int OFF_SIZE   = OFF_LEN + BURST_LEN;
    localparam int OFF_BURST  = OFF_SIZE + 3;
    localparam int OFF_LOCK   = OFF_BURST + 2;
    localparam int OFF_CACHE  = OFF_LOCK + LOCK_WIDTH;
    localparam int OFF_PROT   = OFF_CACHE + 4;
    localparam int OFF_REGION = OFF_PROT + 3;
    localparam int OFF_QOS    = OFF_REGION + 4;

    localparam logic [STREAM_TYPE_WIDTH-1:0] TYPE_AR = STREAM_TYPE_WIDTH'(0);
    localparam logic [STREAM_TYPE_WIDTH-1:0] TYPE_AW = STREAM_TYPE_WIDTH'(1);

    if (ADDR_WIDTH + BURST_LEN + LOCK_WIDTH + 20 > DATA_WIDTH) begin : g_width_check
        $error("axis_to_axi_ax_decoder: packed Ax fields do not fit in DATA_WIDTH");
    end

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BURST_LEN-1:0]  len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [LOCK_WIDTH-1:0] lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            region;
        logic [3:0]            qos;
        logic [USER_WIDTH-1:0] user;
    } ax_t;

    typedef enum logic {
        ST_RUN,
        ST_DROP
    } state_t;

    state_t state;
    ax_t    dec;
    ax_t    ar_slot;
    ax_t    aw_slot;
    logic   ar_full;
    logic   aw_full;

    logic [STREAM_TYPE_WIDTH-1:0] stream_type;
    logic is_ar;
    logic is_aw;
    logic ar_free;
    logic aw_free;
    logic beat_acc;
    logic drop_evt;
    logic ar_hs;
    logic aw_hs;

    // tstrb/tkeep and the bits of tdest/tdata beyond the decoded fields carry
    // no information for this block.
    logic unused_stream_bits;
    assign unused_stream_bits = ^{stream_tstrb, stream_tkeep, stream_tdest, stream_tdata};

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    assign stream_type = stream_tdest[STREAM_TYPE_WIDTH-1:0];
    assign is_ar       = (stream_type == TYPE_AR);
    assign is_aw       = (stream_type == TYPE_AW);

    always_comb begin
        dec        = '0;
        dec.id     = stream_tid;
        dec.addr   = stream_tdata[0 +: ADDR_WIDTH];
        dec.len    = stream_tdata[OFF_LEN +: BURST_LEN];
        dec.size   = stream_tdata[OFF_SIZE +: 3];
        dec.burst  = stream_tdata[OFF_BURST +: 2];
        dec.lock   = stream_tdata[OFF_LOCK +: LOCK_WIDTH];
        dec.cache  = stream_tdata[OFF_CACHE +: 4];
        dec.prot   = stream_tdata[OFF_PROT +: 3];
        dec.region = stream_tdata[OFF_REGION +: 4];
        dec.qos    = stream_tdata[OFF_QOS +: 4];
        dec.user   = stream_tuser;
    end

    // ------------------------------------------------------------------------
    // Flow control: a slot can take a new beat when empty or draining now,
    // which sustains one transaction per clock per channel.
    // ------------------------------------------------------------------------
    assign ar_hs   = ar_full & AXIM_arready;
    assign aw_hs   = aw_full & AXIM_awready;
    assign ar_free = ~ar_full | ar_hs;
    assign aw_free = ~aw_full | aw_hs;

    always_comb begin
        stream_tready = 1'b1;
        if (state == ST_RUN) begin
            if (is_ar) begin
                stream_tready = ar_free;
            end else if (is_aw) begin
                stream_tready = aw_free;
            end
        end
    end

    assign beat_acc = stream_tvalid & stream_tready;

    // Only the first beat of a bad packet is reported; DROP swallows the rest.
    assign drop_evt = beat_acc & (state == ST_RUN) & (~stream_tlast | ~(is_ar | is_aw));

    // ------------------------------------------------------------------------
    // FSM, slots and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            ar_full    <= 1'b0;
            aw_full    <= 1'b0;
            ar_slot    <= '0;
            aw_slot    <= '0;
            decode_err <= 1'b0;
        end else begin
            decode_err <= drop_evt;

            if (ar_hs) begin
                ar_full <= 1'b0;
            end
            if (aw_hs) begin
                aw_full <= 1'b0;
            end

            // A load in the same cycle as a drain overrides the clear above.
            if (beat_acc) begin
                case (state)
                    ST_RUN: begin
                        if (!stream_tlast) begin
                            state <= ST_DROP;
                        end else if (is_ar) begin
                            ar_slot <= dec;
                            ar_full <= 1'b1;
                        end else if (is_aw) begin
                            aw_slot <= dec;
                            aw_full <= 1'b1;
                        end
                    end
                    ST_DROP: begin
                        if (stream_tlast) begin
                            state <= ST_RUN;
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end
    end

    assign AXIM_arvalid  = ar_full;
    assign AXIM_arid     = ar_slot.id;
    assign AXIM_araddr   = ar_slot.addr;
    assign AXIM_arlen    = ar_slot.len;
    assign AXIM_arsize   = ar_slot.size;
    assign AXIM_arburst  = ar_slot.burst;
    assign AXIM_arlock   = ar_slot.lock;
    assign AXIM_arcache  = ar_slot.cache;
    assign AXIM_arprot   = ar_slot.prot;
    assign AXIM_arregion = ar_slot.region;
    assign AXIM_arqos    = ar_slot.qos;
    assign AXIM_aruser   = ar_slot.user;

    assign AXIM_awvalid  = aw_full;
    assign AXIM_awid     = aw_slot.id;
    assign AXIM_awaddr   = aw_slot.addr;
    assign AXIM_awlen    = aw_slot.len;
    assign AXIM_awsize   = aw_slot.size;
    assign AXIM_awburst  = aw_slot.burst;
    assign AXIM_awlock   = aw_slot.lock;
    assign AXIM_awcache  = aw_slot.cache;
    assign AXIM_awprot   = aw_slot.prot;
    assign AXIM_awregion = aw_slot.region;
    assign AXIM_awqos    = aw_slot.qos;
    assign AXIM_awuser   = aw_slot.user;

`ifdef AXIS_TO_AXI_AX_STATS_EN
    // ------------------------------------------------------------------------
    // Saturating statistics; drop_count moves on the same edge that raises
    // decode_err.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_count   <= '0;
            aw_count   <= '0;
            drop_count <= '0;
        end else begin
            if (ar_hs && ar_count != '1) begin
                ar_count <= ar_count + 32'd1;
            end
            if (aw_hs && aw_count != '1) begin
                aw_count <= aw_count + 32'd1;
            end
            if (drop_evt && drop_count != '1) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_to_axi_ax_decoder.sv
// ============================================================================
// tb_axis_to_axi_ax_decoder
//
// Transaction-level reference: accepted single-beat AR/AW packets are pushed
// into per-channel expected queues (at most one entry each), popped on AXI
// handshakes; malformed/unsupported packets schedule an error pulse. A compare
// process checks every DUT output against this model on each falling edge.
// Directed scenarios add literal expectations; a randomized phase follows.
// ============================================================================
module tb_axis_to_axi_ax_decoder;

    logic          clk;
    logic          reset;
    logic [31:0]   stream_tid;
    logic [31:0]   stream_tdest;
    logic [127:0]  stream_tdata;
    logic [15:0]   stream_tstrb;
    logic [15:0]   stream_tkeep;
    logic          stream_tlast;
    logic [63:0]   stream_tuser;
    logic          stream_tvalid;
    logic          stream_tready;

    logic [31:0]   AXIM_arid,     AXIM_awid;
    logic [63:0]   AXIM_araddr,   AXIM_awaddr;
    logic [7:0]    AXIM_arlen,    AXIM_awlen;
    logic [2:0]    AXIM_arsize,   AXIM_awsize;
    logic [1:0]    AXIM_arburst,  AXIM_awburst;
    logic [1:0]    AXIM_arlock,   AXIM_awlock;
    logic [3:0]    AXIM_arcache,  AXIM_awcache;
    logic [2:0]    AXIM_arprot,   AXIM_awprot;
    logic [3:0]    AXIM_arregion, AXIM_awregion;
    logic [3:0]    AXIM_arqos,    AXIM_awqos;
    logic [63:0]   AXIM_aruser,   AXIM_awuser;
    logic          AXIM_arvalid,  AXIM_awvalid;
    logic          AXIM_arready,  AXIM_awready;
    logic          decode_err;
`ifdef AXIS_TO_AXI_AX_STATS_EN
    logic [31:0]   ar_count, aw_count, drop_count;
`endif

    axis_to_axi_ax_decoder #(
        .DATA_WIDTH(128), .ADDR_WIDTH(64), .ID_WIDTH(32), .BURST_LEN(8),
        .LOCK_WIDTH(2), .USER_WIDTH(64), .DEST_WIDTH(32), .STREAM_TYPE_WIDTH(3)
    ) dut (
        .clk(clk), .reset(reset),
        .stream_tid(stream_tid), .stream_tdest(stream_tdest), .stream_tdata(stream_tdata),
        .stream_tstrb(stream_tstrb), .stream_tkeep(stream_tkeep), .stream_tlast(stream_tlast),
        .stream_tuser(stream_tuser), .stream_tvalid(stream_tvalid), .stream_tready(stream_tready),
        .AXIM_arid(AXIM_arid), .AXIM_araddr(AXIM_araddr), .AXIM_arlen(AXIM_arlen),
        .AXIM_arsize(AXIM_arsize), .AXIM_arburst(AXIM_arburst), .AXIM_arlock(AXIM_arlock),
        .AXIM_arcache(AXIM_arcache), .AXIM_arprot(AXIM_arprot), .AXIM_arregion(AXIM_arregion),
        .AXIM_arqos(AXIM_arqos), .AXIM_aruser(AXIM_aruser), .AXIM_arvalid(AXIM_arvalid),
        .AXIM_arready(AXIM_arready),
        .AXIM_awid(AXIM_awid), .AXIM_awaddr(AXIM_awaddr), .AXIM_awlen(AXIM_awlen),
        .AXIM_awsize(AXIM_awsize), .AXIM_awburst(AXIM_awburst), .AXIM_awlock(AXIM_awlock),
        .AXIM_awcache(AXIM_awcache), .AXIM_awprot(AXIM_awprot), .AXIM_awregion(AXIM_awregion),
        .AXIM_awqos(AXIM_awqos), .AXIM_awuser(AXIM_awuser), .AXIM_awvalid(AXIM_awvalid),
        .AXIM_awready(AXIM_awready),
        .decode_err(decode_err)
`ifdef AXIS_TO_AXI_AX_STATS_EN
        , .ar_count(ar_count), .aw_count(aw_count), .drop_count(drop_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------------
    // Checking bookkeeping
    // ------------------------------------------------------------------------
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_err_pulses = 0;
    bit          cmp_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0]  id;
        logic [127:0] data;
        logic [63:0]  user;
    } txn_t;

    txn_t        ar_q[$];
    txn_t        aw_q[$];
    bit          m_in_bad_pkt = 1'b0;
    bit          m_err = 1'b0;
    bit          m_acc;
    int unsigned m_arc = 0, m_awc = 0, m_dropc = 0;

    function automatic logic m_ready();
        logic [2:0] t;
        t = stream_tdest[2:0];
        if (m_in_bad_pkt) return 1'b1;
        if (t == 3'd0) return (ar_q.size() == 0) || AXIM_arready;
        if (t == 3'd1) return (aw_q.size() == 0) || AXIM_awready;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_q.delete();
            aw_q.delete();
            m_in_bad_pkt = 1'b0;
            m_err = 1'b0;
            m_arc = 0; m_awc = 0; m_dropc = 0;
        end else begin
            m_acc = stream_tvalid && m_ready();
            m_err = 1'b0;
            if (ar_q.size() != 0 && AXIM_arready) begin
                void'(ar_q.pop_front());
                m_arc++;
            end
            if (aw_q.size() != 0 && AXIM_awready) begin
                void'(aw_q.pop_front());
                m_awc++;
            end
            if (m_acc) begin
                if (m_in_bad_pkt) begin
                    if (stream_tlast) m_in_bad_pkt = 1'b0;
                end else if (!stream_tlast) begin
                    m_in_bad_pkt = 1'b1;
                    m_err = 1'b1;
                end else if (stream_tdest[2:0] == 3'd0) begin
                    ar_q.push_back('{stream_tid, stream_tdata, stream_tuser});
                end else if (stream_tdest[2:0] == 3'd1) begin
                    aw_q.push_back('{stream_tid, stream_tdata, stream_tuser});
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_err) m_dropc++;
        end
    end

    task automatic cmp_ax(input string ch, input logic vld, input bit have, input txn_t t,
                          input logic [31:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] lock,
                          input logic [3:0] cache, input logic [2:0] prot, input logic [3:0] region,
                          input logic [3:0] qos, input logic [63:0] user);
        chk({ch, "valid"}, vld, have);
        if (have) begin
            chk({ch, "id"},     id,     t.id);
            chk({ch, "addr"},   addr,   t.data[63:0]);
            chk({ch, "len"},    len,    t.data[71:64]);
            chk({ch, "size"},   size,   t.data[74:72]);
            chk({ch, "burst"},  burst,  t.data[76:75]);
            chk({ch, "lock"},   lock,   t.data[78:77]);
            chk({ch, "cache"},  cache,  t.data[82:79]);
            chk({ch, "prot"},   prot,   t.data[85:83]);
            chk({ch, "region"}, region, t.data[89:86]);
            chk({ch, "qos"},    qos,    t.data[93:90]);
            chk({ch, "user"},   user,   t.user);
        end
    endtask

    always @(negedge clk) begin
        if (decode_err === 1'b1) n_err_pulses++;
        if (cmp_en) begin
            txn_t ea, ew;
            ea = '{default: '0};
            ew = '{default: '0};
            if (ar_q.size() != 0) ea = ar_q[0];
            if (aw_q.size() != 0) ew = aw_q[0];
            chk("tready", stream_tready, m_ready());
            chk("decode_err", decode_err, m_err);
            cmp_ax("ar", AXIM_arvalid, ar_q.size() != 0, ea, AXIM_arid, AXIM_araddr, AXIM_arlen,
                   AXIM_arsize, AXIM_arburst, AXIM_arlock, AXIM_arcache, AXIM_arprot,
                   AXIM_arregion, AXIM_arqos, AXIM_aruser);
            cmp_ax("aw", AXIM_awvalid, aw_q.size() != 0, ew, AXIM_awid, AXIM_awaddr, AXIM_awlen,
                   AXIM_awsize, AXIM_awburst, AXIM_awlock, AXIM_awcache, AXIM_awprot,
                   AXIM_awregion, AXIM_awqos, AXIM_awuser);
`ifdef AXIS_TO_AXI_AX_STATS_EN
            chk("ar_count", ar_count, m_arc);
            chk("aw_count", aw_count, m_awc);
            chk("drop_count", drop_count, m_dropc);
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1ns after the rising edge)
    // ------------------------------------------------------------------------
    function automatic logic [127:0] mk(input logic [63:0] addr, input logic [7:0] len,
                                        input logic [2:0] size, input logic [1:0] burst,
                                        input logic [1:0] lock, input logic [3:0] cache,
                                        input logic [2:0] prot, input logic [3:0] region,
                                        input logic [3:0] qos);
        return {34'b0, qos, region, prot, cache, lock, burst, size, len, addr};
    endfunction

    task automatic drive(input logic [31:0] dest, input logic [31:0] id,
                         input logic [127:0] data, input logic [63:0] user, input logic last);
        stream_tdest  = dest;
        stream_tid    = id;
        stream_tdata  = data;
        stream_tuser  = user;
        stream_tlast  = last;
        stream_tstrb  = 16'($urandom);
        stream_tkeep  = 16'($urandom);
        stream_tvalid = 1'b1;
    endtask

    task automatic beat(input logic [31:0] dest, input logic [31:0] id,
                        input logic [127:0] data, input logic [63:0] user, input logic last);
        logic r;
        int unsigned n;
        drive(dest, id, data, user, last);
        n = 0;
        r = 1'b0;
        while (!r && n < 100) begin
            @(negedge clk);
            r = stream_tready;
            @(posedge clk);
            n++;
        end
        chk("beat_accepted", r, 1'b1);
        #1;
        stream_tvalid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    int unsigned err_before;
    logic        r;
    int unsigned sel;

    initial begin
        reset = 1'b1;
        stream_tvalid = 1'b0;
        stream_tdest = '0; stream_tid = '0; stream_tdata = '0; stream_tuser = '0;
        stream_tlast = 1'b0; stream_tstrb = '0; stream_tkeep = '0;
        AXIM_arready = 1'b0;
        AXIM_awready = 1'b0;
        step();
        cmp_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_arvalid", AXIM_arvalid, 1'b0);
        chk("rst_awvalid", AXIM_awvalid, 1'b0);
        chk("rst_decode_err", decode_err, 1'b0);
        chk("rst_araddr", AXIM_araddr, 64'h0);
        chk("rst_awid", AXIM_awid, 32'h0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", stream_tready, 1'b1);
        step();

        // AR replay
        AXIM_arready = 1'b1;
        beat(32'd0, 32'd5, mk(64'h1000, 8'd3, 3'd4, 2'd1, 2'd0, 4'd0, 3'd0, 4'd0, 4'd0),
             64'hAB, 1'b1);
        @(negedge clk);
        chk("ar_replay_valid", AXIM_arvalid, 1'b1);
        chk("ar_replay_id", AXIM_arid, 32'd5);
        chk("ar_replay_addr", AXIM_araddr, 64'h1000);
        chk("ar_replay_len", AXIM_arlen, 8'd3);
        chk("ar_replay_size", AXIM_arsize, 3'd4);
        chk("ar_replay_burst", AXIM_arburst, 2'd1);
        chk("ar_replay_user", AXIM_aruser, 64'hAB);
        @(negedge clk);
        chk("ar_replay_done", AXIM_arvalid, 1'b0);
        step();

        // AW backpressure: second beat waits, first held stable
        AXIM_awready = 1'b0;
        beat(32'd1, 32'd1, mk(64'hA1A0, 8'd7, 3'd2, 2'd2, 2'd1, 4'd3, 3'd5, 4'd9, 4'd6),
             64'h11, 1'b1);
        drive(32'd1, 32'd2, mk(64'hB2B0, 8'd1, 3'd3, 2'd0, 2'd2, 4'd15, 3'd7, 4'd1, 4'd2),
              64'h22, 1'b1);
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_tready_low", stream_tready, 1'b0);
            chk("bp_awid_held", AXIM_awid, 32'd1);
            chk("bp_awaddr_held", AXIM_awaddr, 64'hA1A0);
            step();
        end
        AXIM_awready = 1'b1;
        @(negedge clk);
        chk("bp_tready_release", stream_tready, 1'b1);
        step();
        stream_tvalid = 1'b0;
        @(negedge clk);
        chk("bp_second_valid", AXIM_awvalid, 1'b1);
        chk("bp_second_id", AXIM_awid, 32'd2);
        step();
        @(negedge clk);
        chk("bp_drained", AXIM_awvalid, 1'b0);
        step();

        // Independence: AW stalled and full, AR still flows
        AXIM_awready = 1'b0;
        beat(32'd1, 32'd3, mk(64'hC000, 8'd0, 3'd0, 2'd1, 2'd0, 4'd0, 3'd0, 4'd0, 4'd0),
             64'h33, 1'b1);
        beat(32'd0, 32'd7, mk(64'hD000, 8'd2, 3'd1, 2'd1, 2'd0, 4'd0, 3'd0, 4'd0, 4'd0),
             64'h44, 1'b1);
        @(negedge clk);
        chk("indep_arvalid", AXIM_arvalid, 1'b1);
        chk("indep_arid", AXIM_arid, 32'd7);
        chk("indep_awvalid", AXIM_awvalid, 1'b1);
        step();
        AXIM_awready = 1'b1;
        repeat (2) step();

        // Malformed 3-beat AW packet: one error pulse, no AW activity
        err_before = n_err_pulses;
        beat(32'd1, 32'd20, mk(64'hE0, 8'd0, 3'd0, 2'd0, 2'd0, 4'd0, 3'd0, 4'd0, 4'd0), 64'h0, 1'b0);
        beat(32'd1, 32'd21, mk(64'hE1, 8'd0, 3'd0, 2'd0, 2'd0, 4'd0, 3'd0, 4'd0, 4'd0), 64'h0, 1'b0);
        beat(32'd1, 32'd22, mk(64'hE2, 8'd0, 3'd0, 2'd0, 2'd0, 4'd0, 3'd0, 4'd0, 4'd0), 64'h0, 1'b1);
        @(negedge clk);
        chk("malformed_no_awvalid", AXIM_awvalid, 1'b0);
        step();
        chk("malformed_err_pulses", n_err_pulses - err_before, 1);
        beat(32'd0, 32'd23, mk(64'hF00, 8'd4, 3'd3, 2'd1, 2'd0, 4'd0, 3'd0, 4'd0, 4'd0),
             64'h55, 1'b1);
        @(negedge clk);
        chk("after_bad_arvalid", AXIM_arvalid, 1'b1);
        chk("after_bad_araddr", AXIM_araddr, 64'hF00);
        step();

        // Unsupported type W (3): consumed, single-cycle error
        beat(32'd3, 32'd30, '0, 64'h0, 1'b1);
        @(negedge clk);
        chk("unsup_err_high", decode_err, 1'b1);
        chk("unsup_no_aw", AXIM_awvalid, 1'b0);
`ifdef AXIS_TO_AXI_AX_STATS_EN
        // one drop from the malformed packet plus this one
        chk("unsup_drop_count", drop_count, 32'd2);
`endif
        step();
        @(negedge clk);
        chk("unsup_err_low", decode_err, 1'b0);
        step();

        // Reset mid-operation: AR slot full and FSM discarding a packet
        AXIM_arready = 1'b0;
        beat(32'd0, 32'd9, mk(64'h9000, 8'd1, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0, 4'd0, 4'd0),
             64'h99, 1'b1);
        beat(32'd2, 32'd10, '0, 64'h0, 1'b0);
        @(negedge clk);
        chk("mid_rst_arvalid_before", AXIM_arvalid, 1'b1);
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_arvalid", AXIM_arvalid, 1'b0);
        chk("mid_rst_araddr", AXIM_araddr, 64'h0);
        chk("mid_rst_arid", AXIM_arid, 32'h0);
        repeat (2) step();
        reset = 1'b0;
        AXIM_arready = 1'b1;
        @(negedge clk);
        chk("mid_rst_tready", stream_tready, 1'b1);
        step();
        beat(32'd0, 32'd11, mk(64'h7700, 8'd5, 3'd1, 2'd2, 2'd0, 4'd0, 3'd0, 4'd0, 4'd0),
             64'h77, 1'b1);
        @(negedge clk);
        chk("mid_rst_replay_valid", AXIM_arvalid, 1'b1);
        chk("mid_rst_replay_id", AXIM_arid, 32'd11);
        step();

        // Randomized traffic with random downstream readiness
        stream_tvalid = 1'b0;
        for (int unsigned c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = stream_tready;
            step();
            if (stream_tvalid && r) stream_tvalid = 1'b0;
            AXIM_arready = ($urandom_range(0, 3) != 0);
            AXIM_awready = ($urandom_range(0, 3) != 0);
            if (!stream_tvalid && $urandom_range(0, 3) != 0) begin
                logic [31:0] dest;
                dest = $urandom;
                sel  = $urandom_range(0, 9);
                if (sel < 4)      dest[2:0] = 3'd0;
                else if (sel < 8) dest[2:0] = 3'd1;
                else              dest[2:0] = 3'($urandom_range(2, 7));
                drive(dest, $urandom, {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom}, ($urandom_range(0, 9) != 0));
            end
        end

        // Let the last beat and slots drain
        AXIM_arready = 1'b1;
        AXIM_awready = 1'b1;
        stream_tlast = 1'b1;
        repeat (4) step();
        stream_tvalid = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
